// File: rtl/uvme_axil_st_txn_chkr.sv
// uvme_axil_st_txn_chkr: passive AXI-Lite checker pairing AW/W, tracking outstanding writes/reads and flagging protocol errors.
// Define UVME_AXIL_ST_TXN_CHKR_STABILITY_EN to enable the valid/payload stability check on err_flags[8].
module uvme_axil_st_txn_chkr #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int TIMEOUT_CYCLES  = 256,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr,
  input  logic                  awvalid,
  input  logic                  awready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  wvalid,
  input  logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  bvalid,
  input  logic                  bready,
  input  logic [1:0]            bresp,
  input  logic                  arvalid,
  input  logic                  arready,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  rvalid,
  input  logic                  rready,
  input  logic [1:0]            rresp,
  output logic [CW-1:0]         wr_outstanding,
  output logic [CW-1:0]         rd_outstanding,
  output logic [8:0]            err_flags,
  output logic [15:0]           err_cnt,
  output logic [31:0]           wr_done_cnt,
  output logic [31:0]           rd_done_cnt
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] MAX = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [CW-1:0] aw_pend, w_pend, aw_sum, w_sum, aw_pend_n, w_pend_n, wr_n, rd_n;
  logic [TW-1:0] wr_timer, rd_timer, wr_timer_n, rd_timer_n;
  logic aw_ovf, w_ovf, wr_ovf, rd_ovf, pair, b_ok, r_ok, wr_to, rd_to, stab;
  logic [8:0] ev;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign b_hs  = bvalid & bready;
  assign ar_hs = arvalid & arready;
  assign r_hs  = rvalid & rready;
  // Pending AW/W counts saturate; a pair consumes one of each after this cycle's arrivals.
  always_comb begin
    aw_ovf     = aw_hs && aw_pend == MAX;
    w_ovf      = w_hs && w_pend == MAX;
    aw_sum     = aw_pend + CW'(aw_hs && !aw_ovf);
    w_sum      = w_pend + CW'(w_hs && !w_ovf);
    pair       = aw_sum != '0 && w_sum != '0;
    aw_pend_n  = aw_sum - CW'(pair);
    w_pend_n   = w_sum - CW'(pair);
    b_ok       = b_hs && wr_outstanding != '0;
    r_ok       = r_hs && rd_outstanding != '0;
    wr_ovf     = pair && !b_ok && wr_outstanding == MAX;
    rd_ovf     = ar_hs && !r_ok && rd_outstanding == MAX;
    wr_n       = (pair && !b_ok && !wr_ovf) ? wr_outstanding + CW'(1) :
                 (b_ok && !pair) ? wr_outstanding - CW'(1) : wr_outstanding;
    rd_n       = (ar_hs && !r_ok && !rd_ovf) ? rd_outstanding + CW'(1) :
                 (r_ok && !ar_hs) ? rd_outstanding - CW'(1) : rd_outstanding;
    wr_timer_n = (b_hs || wr_outstanding == '0) ? '0 : (wr_timer == TMO) ? wr_timer : wr_timer + TW'(1);
    rd_timer_n = (r_hs || rd_outstanding == '0) ? '0 : (rd_timer == TMO) ? rd_timer : rd_timer + TW'(1);
    wr_to      = wr_timer_n == TMO && wr_timer != TMO;
    rd_to      = rd_timer_n == TMO && rd_timer != TMO;
    ev         = {stab, r_hs && rresp != 2'b00, b_hs && bresp != 2'b00, rd_to, wr_to, rd_ovf,
                  aw_ovf || w_ovf || wr_ovf, r_hs && !r_ok, b_hs && !b_ok};
  end
`ifdef UVME_AXIL_ST_TXN_CHKR_STABILITY_EN
  logic [4:0] stall_q, vld, chg;
  logic [ADDR_WIDTH-1:0] awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0] bresp_q, rresp_q;
  assign vld  = {awvalid, wvalid, bvalid, arvalid, rvalid};
  assign chg  = {awaddr != awaddr_q, wdata != wdata_q, bresp != bresp_q, araddr != araddr_q, rresp != rresp_q};
  assign stab = |(stall_q & (~vld | chg));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q  <= '0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      bresp_q  <= '0;
      araddr_q <= '0;
      rresp_q  <= '0;
    end else begin
      stall_q  <= vld & ~{awready, wready, bready, arready, rready};
      awaddr_q <= awaddr;
      wdata_q  <= wdata;
      bresp_q  <= bresp;
      araddr_q <= araddr;
      rresp_q  <= rresp;
    end
  end
`else
  logic unused_payload;
  assign unused_payload = ^{awaddr, wdata, araddr};
  assign stab = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_pend        <= '0;
      w_pend         <= '0;
      wr_outstanding <= '0;
      rd_outstanding <= '0;
      wr_timer       <= '0;
      rd_timer       <= '0;
      err_flags      <= '0;
      err_cnt        <= '0;
      wr_done_cnt    <= '0;
      rd_done_cnt    <= '0;
    end else begin
      aw_pend        <= aw_pend_n;
      w_pend         <= w_pend_n;
      wr_outstanding <= wr_n;
      rd_outstanding <= rd_n;
      wr_timer       <= wr_timer_n;
      rd_timer       <= rd_timer_n;
      wr_done_cnt    <= wr_done_cnt + 32'(b_ok);
      rd_done_cnt    <= rd_done_cnt + 32'(r_ok);
      err_flags      <= clr ? ev : err_flags | ev;
      err_cnt        <= clr ? 16'(|ev) : (|ev && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
    end
  end
endmodule

// File: tb/tb_uvme_axil_st_txn_chkr.sv
// tb_uvme_axil_st_txn_chkr: directed table, corner sequences and randomized traffic against a counting reference model.
module tb_uvme_axil_st_txn_chkr;
  localparam int AW = 32, DW = 32, MAXO = 4, TO = 16, CW = $clog2(MAXO + 1);
`ifdef UVME_AXIL_ST_TXN_CHKR_STABILITY_EN
  localparam int STAB = 1;
`else
  localparam int STAB = 0;
`endif
  logic clk = 0, reset_n = 0, clr = 0;
  logic awvalid = 0, awready = 0, wvalid = 0, wready = 0, bvalid = 0, bready = 0;
  logic arvalid = 0, arready = 0, rvalid = 0, rready = 0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [1:0] bresp = '0, rresp = '0;
  logic [CW-1:0] wr_outstanding, rd_outstanding;
  logic [8:0] err_flags;
  logic [15:0] err_cnt;
  logic [31:0] wr_done_cnt, rd_done_cnt;
  always #5 clk = ~clk;
  uvme_axil_st_txn_chkr #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rresp(rresp),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding),
    .err_flags(err_flags), .err_cnt(err_cnt),
    .wr_done_cnt(wr_done_cnt), .rd_done_cnt(rd_done_cnt));
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference model: plain integer bookkeeping of the checker rules.
  int m_aw, m_w, m_wr, m_rd, m_wt, m_rt, m_err;
  logic [8:0] m_flags;
  logic [31:0] m_wdone, m_rdone;
  logic [4:0] m_stall;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [DW-1:0] m_wdata;
  logic [1:0] m_bresp, m_rresp;
  task automatic model_reset();
    m_aw = 0; m_w = 0; m_wr = 0; m_rd = 0; m_wt = 0; m_rt = 0; m_err = 0;
    m_flags = '0; m_wdone = '0; m_rdone = '0; m_stall = '0;
    m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_bresp = '0; m_rresp = '0;
  endtask
  task automatic model_step();
    logic [8:0] ev = '0;
    logic [4:0] vld;
    int ap, wp, nwr, nrd, nwt, nrt;
    bit awh, wh, bh, arh, rh, pair, bok, rok;
    awh = awvalid && awready; wh = wvalid && wready; bh = bvalid && bready;
    arh = arvalid && arready; rh = rvalid && rready;
    ap = m_aw + int'(awh);
    wp = m_w + int'(wh);
    if (ap > MAXO) begin ap = MAXO; ev[2] = 1; end
    if (wp > MAXO) begin wp = MAXO; ev[2] = 1; end
    pair = ap > 0 && wp > 0;
    if (pair) begin ap--; wp--; end
    bok = bh && m_wr > 0;
    rok = rh && m_rd > 0;
    ev[0] = bh && !bok;
    ev[1] = rh && !rok;
    nwr = m_wr;
    if (pair && !bok) begin if (m_wr == MAXO) ev[2] = 1; else nwr++; end
    else if (bok && !pair) nwr--;
    nrd = m_rd;
    if (arh && !rok) begin if (m_rd == MAXO) ev[3] = 1; else nrd++; end
    else if (rok && !arh) nrd--;
    if (bh || m_wr == 0) nwt = 0;
    else if (m_wt < TO) begin nwt = m_wt + 1; if (nwt == TO) ev[4] = 1; end
    else nwt = m_wt;
    if (rh || m_rd == 0) nrt = 0;
    else if (m_rt < TO) begin nrt = m_rt + 1; if (nrt == TO) ev[5] = 1; end
    else nrt = m_rt;
    ev[6] = bh && bresp != 0;
    ev[7] = rh && rresp != 0;
    vld = {awvalid, wvalid, bvalid, arvalid, rvalid};
    if (STAB != 0) begin
      ev[8] = (m_stall[4] && (!vld[4] || awaddr != m_awaddr)) || (m_stall[3] && (!vld[3] || wdata != m_wdata)) ||
              (m_stall[2] && (!vld[2] || bresp != m_bresp)) || (m_stall[1] && (!vld[1] || araddr != m_araddr)) ||
              (m_stall[0] && (!vld[0] || rresp != m_rresp));
    end
    m_stall = vld & ~{awready, wready, bready, arready, rready};
    m_awaddr = awaddr; m_wdata = wdata; m_bresp = bresp; m_araddr = araddr; m_rresp = rresp;
    if (bok) m_wdone++;
    if (rok) m_rdone++;
    m_aw = ap; m_w = wp; m_wr = nwr; m_rd = nrd; m_wt = nwt; m_rt = nrt;
    m_flags = clr ? ev : (m_flags | ev);
    if (clr) m_err = (ev != 0) ? 1 : 0;
    else if (ev != 0 && m_err < 65535) m_err++;
  endtask
  task automatic tick();
    if (!reset_n) model_reset(); else model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; bvalid = 0; bready = 0;
    arvalid = 0; arready = 0; rvalid = 0; rready = 0; clr = 0; bresp = 0; rresp = 0;
  endtask
  task automatic hs(input bit aw, input bit w, input bit b, input bit ar, input bit r);
    awvalid = aw; awready = aw; wvalid = w; wready = w; bvalid = b; bready = b;
    arvalid = ar; arready = ar; rvalid = r; rready = r;
  endtask
  task automatic chk_model(input string tag);
    chk({tag, ".wr_out"}, 64'(wr_outstanding), 64'(m_wr));
    chk({tag, ".rd_out"}, 64'(rd_outstanding), 64'(m_rd));
    chk({tag, ".flags"}, 64'(err_flags), 64'(m_flags));
    chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_err));
    chk({tag, ".wr_done"}, 64'(wr_done_cnt), 64'(m_wdone));
    chk({tag, ".rd_done"}, 64'(rd_done_cnt), 64'(m_rdone));
  endtask
  task automatic do_reset();
    idle();
    reset_n = 0;
    model_reset();
    #1;
    chk("rst.wr_out", 64'(wr_outstanding), 0);
    chk("rst.rd_out", 64'(rd_outstanding), 0);
    chk("rst.flags", 64'(err_flags), 0);
    chk("rst.err_cnt", 64'(err_cnt), 0);
    chk("rst.wr_done", 64'(wr_done_cnt), 0);
    chk("rst.rd_done", 64'(rd_done_cnt), 0);
    tick();
    tick();
    reset_n = 1;
  endtask
  typedef struct {
    int aw, w, b, ar, r, clr, bresp, rresp, wr, rd, flags, err;
  } vec_t;
  function automatic vec_t v(int aw, int w, int b, int ar, int r, int c, int br, int rr,
                             int wr, int rd, int flags, int err);
    vec_t t;
    t = '{aw, w, b, ar, r, c, br, rr, wr, rd, flags, err};
    return t;
  endfunction
  vec_t tbl[16];
  initial begin
    tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000, 0);
    tbl[1]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000, 0);
    tbl[2]  = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h000, 0);
    tbl[3]  = v(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 'h000, 0);
    tbl[4]  = v(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'h000, 0);
    tbl[5]  = v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'h000, 0);
    tbl[6]  = v(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 'h000, 0);
    tbl[7]  = v(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 'h000, 0);
    tbl[8]  = v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'h001, 1);
    tbl[9]  = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h000, 0);
    tbl[10] = v(1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 'h000, 0);
    tbl[11] = v(1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 'h040, 1);
    tbl[12] = v(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 'h042, 2);
    tbl[13] = v(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 'h002, 1);
    tbl[14] = v(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'h002, 1);
    tbl[15] = v(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h000, 0);
    do_reset();
    foreach (tbl[i]) begin
      hs(tbl[i].aw != 0, tbl[i].w != 0, tbl[i].b != 0, tbl[i].ar != 0, tbl[i].r != 0);
      clr = tbl[i].clr != 0;
      bresp = 2'(tbl[i].bresp);
      rresp = 2'(tbl[i].rresp);
      tick();
      chk($sformatf("tbl%0d.wr_out", i), 64'(wr_outstanding), 64'(tbl[i].wr));
      chk($sformatf("tbl%0d.rd_out", i), 64'(rd_outstanding), 64'(tbl[i].rd));
      chk($sformatf("tbl%0d.flags", i), 64'(err_flags), 64'(tbl[i].flags));
      chk($sformatf("tbl%0d.err_cnt", i), 64'(err_cnt), 64'(tbl[i].err));
    end
    idle();
    chk("tbl.wr_done", 64'(wr_done_cnt), 3);
    chk("tbl.rd_done", 64'(rd_done_cnt), 1);
    // Read overflow at MAX_OUTSTANDING, then drain.
    for (int i = 0; i < 5; i++) begin hs(0, 0, 0, 1, 0); tick(); end
    idle();
    chk("ovf.rd_out", 64'(rd_outstanding), 4);
    chk("ovf.flags", 64'(err_flags), 'h008);
    chk("ovf.err_cnt", 64'(err_cnt), 1);
    for (int i = 0; i < 4; i++) begin hs(0, 0, 0, 0, 1); tick(); end
    idle();
    chk("drain.rd_out", 64'(rd_outstanding), 0);
    chk("drain.rd_done", 64'(rd_done_cnt), 5);
    clr = 1; tick(); clr = 0;
    // Read timeout exactly at TIMEOUT_CYCLES, then an error response.
    hs(0, 0, 0, 1, 0); tick(); idle();
    for (int i = 0; i < TO - 1; i++) tick();
    chk("to.early", 64'(err_flags[5]), 0);
    tick();
    chk("to.flag5", 64'(err_flags), 'h020);
    chk("to.err_cnt", 64'(err_cnt), 1);
    hs(0, 0, 0, 0, 1); rresp = 2'b10; tick(); idle();
    chk("rresp.flags", 64'(err_flags), 'h0A0);
    chk("rresp.err_cnt", 64'(err_cnt), 2);
    chk("rresp.rd_out", 64'(rd_outstanding), 0);
    clr = 1; tick(); clr = 0;
    // Address change while AW is stalled.
    awvalid = 1; awready = 0; awaddr = 32'h10; tick();
    awaddr = 32'h14; tick();
    chk("stab.flag8", 64'(err_flags[8]), 64'(STAB));
    awready = 1; tick(); idle();
    hs(0, 1, 0, 0, 0); tick();
    chk("stab.wr_out", 64'(wr_outstanding), 1);
    hs(0, 0, 1, 0, 0); tick(); idle();
    chk("stab.wr_out0", 64'(wr_outstanding), 0);
    chk_model("stab");
    clr = 1; tick(); clr = 0;
    // Reset with reads in flight: a late R becomes an orphan.
    hs(0, 0, 0, 1, 0); tick(); tick(); idle();
    chk("pre_rst.rd_out", 64'(rd_outstanding), 2);
    do_reset();
    hs(0, 0, 0, 0, 1); tick(); idle();
    chk("post_rst.flags", 64'(err_flags), 'h002);
    chk("post_rst.err_cnt", 64'(err_cnt), 1);
    chk("post_rst.rd_out", 64'(rd_outstanding), 0);
    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      awvalid = 1'($urandom_range(0, 1)); awready = 1'($urandom_range(0, 1));
      wvalid = 1'($urandom_range(0, 1)); wready = 1'($urandom_range(0, 1));
      bvalid = 1'($urandom_range(0, 3) == 0); bready = 1'($urandom_range(0, 1));
      arvalid = 1'($urandom_range(0, 1)); arready = 1'($urandom_range(0, 1));
      rvalid = 1'($urandom_range(0, 2) == 0); rready = 1'($urandom_range(0, 1));
      bresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rresp = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      if ($urandom_range(0, 3) == 0) awaddr = $urandom;
      if ($urandom_range(0, 3) == 0) wdata = $urandom;
      if ($urandom_range(0, 3) == 0) araddr = $urandom;
      clr = 1'($urandom_range(0, 31) == 0);
      tick();
      chk_model("rnd");
    end
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
